// File: rtl/cache_fill_arbiter.sv
// Main-memory port arbiter between the I-cache fill FSM and the D-cache miss/write FSM.
// Define CACHE_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module cache_fill_arbiter #(
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     d_req,
    input  logic                     d_wr,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [DATA_W-1:0]        d_wdata,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_valid,
    output logic                     i_gnt,
    output logic                     d_gnt,
    output logic                     fill_valid,
    output logic [$clog2(WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]        fill_data,
    output logic                     i_done,
    output logic                     d_done,
    output logic                     i_busy,
    output logic                     d_busy
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);

    if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_param_check
        $error("cache_fill_arbiter: WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_next;
    logic               owner;      // 0 = I side, 1 = D side
    logic               op_wr;
    logic [ADDR_W-1:0]  base;       // block base for fills, word address for writes
    logic [DATA_W-1:0]  wdata;
    logic [CNT_W-1:0]   iss_cnt;
    logic [CNT_W-1:0]   ret_cnt;
    logic               any_req;
    logic               pick_d;
    logic [ADDR_W-1:0]  pick_base;
    logic               fill_hit;

    assign any_req = i_req | d_req;

`ifdef CACHE_ARB_RR_EN
    logic last_served;  // side granted most recently; reset value I lets D win the first tie
    assign pick_d = d_req & (~i_req | ~last_served);
`else
    assign pick_d = d_req;
`endif

    assign pick_base = !pick_d ? (i_addr & BLK_MASK) :
                       d_wr    ? {d_addr[ADDR_W-1:1], 1'b0} :
                                 (d_addr & BLK_MASK);

    // Returns are only meaningful while a fill is in flight; stale ones after a reset land in IDLE/DONE.
    assign fill_hit = mem_valid & ~op_wr & ((state == ISSUE) | (state == WAIT));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= 1'b0;
            op_wr   <= 1'b0;
            base    <= '0;
            wdata   <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
`ifdef CACHE_ARB_RR_EN
            last_served <= 1'b0;
`endif
        end else begin
            if (state == IDLE && any_req) begin
                owner   <= pick_d;
                op_wr   <= pick_d & d_wr;
                base    <= pick_base;
                wdata   <= d_wdata;
                iss_cnt <= '0;
                ret_cnt <= '0;
`ifdef CACHE_ARB_RR_EN
                last_served <= pick_d;
`endif
            end
            if (state == ISSUE && !op_wr) iss_cnt <= iss_cnt + CNT_W'(1);
            if (fill_hit)                 ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (any_req) state_next = ISSUE;
            ISSUE: begin
                if (op_wr)                                state_next = DONE;
                else if (iss_cnt == CNT_W'(WORDS - 1))    state_next = WAIT;
            end
            WAIT:  if (fill_hit && ret_cnt == CNT_W'(WORDS - 1)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = fill_hit;
        fill_idx   = '0;
        fill_data  = '0;
        i_gnt      = (state != IDLE) & ~owner;
        d_gnt      = (state != IDLE) & owner;
        i_done     = (state == DONE) & ~owner;
        d_done     = (state == DONE) & owner;
        if (state == ISSUE) begin
            mem_en = 1'b1;
            if (op_wr) begin
                mem_wr    = 1'b1;
                mem_addr  = base;
                mem_wdata = wdata;
            end else begin
                mem_addr = base + ADDR_W'({iss_cnt[IDX_W-1:0], 1'b0});
            end
        end
        if (fill_hit) begin
            fill_idx  = ret_cnt[IDX_W-1:0];
            fill_data = mem_rdata;
        end
        i_busy = i_req & ~i_done;
        d_busy = d_req & ~d_done;
    end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: a timeline reference model predicts every memory issue,
// fill word, grant window and done pulse; a monitor compares them against the DUT each cycle.
module tb_cache_fill_arbiter;
    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;
    localparam int IDX_W   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0]       i_addr = '0, d_addr = '0, d_wdata = '0;
    logic              mem_en, mem_wr;
    logic [15:0]       mem_addr, mem_wdata;
    logic [15:0]       mem_rdata = '0;
    logic              mem_valid = 1'b0;
    logic              i_gnt, d_gnt, fill_valid, i_done, d_done, i_busy, d_busy;
    logic [IDX_W-1:0]  fill_idx;
    logic [15:0]       fill_data;

    cache_fill_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .i_gnt(i_gnt), .d_gnt(d_gnt),
        .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .i_busy(i_busy), .d_busy(d_busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [15:0] addr; logic wr; logic [15:0] data; } iss_t;
    typedef struct { int cyc; int idx; logic [15:0] data; logic side; } fill_t;
    typedef struct { int cyc; logic side; } done_t;

    iss_t        q_iss[$];
    fill_t       q_fill[$];
    done_t       q_done[$];
    logic [15:0] mem_arr [0:32767];
    logic [15:0] ref_arr [0:32767];
    logic [15:0] sched [int];   // memory return data keyed by the cycle it appears

    int   total = 0, bad = 0, cyc = 0;
    int   i_done_cnt = 0, gi_cnt = 0, gd_cnt = 0;
    logic prev_i_gnt = 1'b0, prev_d_gnt = 1'b0;
    logic act = 1'b0, act_side = 1'b0, last_served = 1'b0;
    int   act_g = 0, act_end = 0;

    task automatic check(input string name, input bit ok, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    initial begin
        for (int k = 0; k < 32768; k++) begin
            mem_arr[k] = 16'($urandom);
            ref_arr[k] = mem_arr[k];
        end
    end

    // Start of each cycle: advance the cycle count and present any scheduled memory return.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (sched.exists(cyc)) begin
            mem_valid = 1'b1;
            mem_rdata = sched[cyc];
            sched.delete(cyc);
        end else begin
            mem_valid = 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    task automatic monitor_cycle();
        iss_t  e;
        fill_t f;
        done_t d;
        logic  in_win = act && cyc >= act_g && cyc <= act_end;
        logic  exp_i_done = act && !act_side && cyc == act_end;
        logic  exp_d_done = act && act_side && cyc == act_end;
        check("i_gnt", i_gnt === (in_win && !act_side), $sformatf("cyc %0d got %b want %b", cyc, i_gnt, in_win && !act_side));
        check("d_gnt", d_gnt === (in_win && act_side), $sformatf("cyc %0d got %b want %b", cyc, d_gnt, in_win && act_side));
        check("i_busy", i_busy === (i_req && !exp_i_done), $sformatf("cyc %0d got %b want %b", cyc, i_busy, i_req && !exp_i_done));
        check("d_busy", d_busy === (d_req && !exp_d_done), $sformatf("cyc %0d got %b want %b", cyc, d_busy, d_req && !exp_d_done));

        if (mem_en === 1'b1) begin
            if (q_iss.size() == 0)
                check("mem_issue", 1'b0, $sformatf("cyc %0d got unexpected access addr %h wr %b, want none", cyc, mem_addr, mem_wr));
            else begin
                e = q_iss.pop_front();
                check("mem_issue", e.cyc == cyc && e.addr == mem_addr && e.wr == mem_wr && (!e.wr || e.data == mem_wdata),
                      $sformatf("got cyc %0d addr %h wr %b data %h, want cyc %0d addr %h wr %b data %h",
                                cyc, mem_addr, mem_wr, mem_wdata, e.cyc, e.addr, e.wr, e.data));
            end
        end else if (q_iss.size() > 0 && q_iss[0].cyc <= cyc) begin
            e = q_iss.pop_front();
            check("mem_issue", 1'b0, $sformatf("cyc %0d got no access, want addr %h wr %b", cyc, e.addr, e.wr));
        end

        if (fill_valid === 1'b1) begin
            if (q_fill.size() == 0)
                check("fill", 1'b0, $sformatf("cyc %0d got unexpected fill idx %0d data %h, want none", cyc, fill_idx, fill_data));
            else begin
                f = q_fill.pop_front();
                check("fill", f.cyc == cyc && f.idx == int'(fill_idx) && f.data == fill_data && (f.side ? d_gnt : i_gnt),
                      $sformatf("got cyc %0d idx %0d data %h gnt i%b d%b, want cyc %0d idx %0d data %h side %0d",
                                cyc, fill_idx, fill_data, i_gnt, d_gnt, f.cyc, f.idx, f.data, f.side));
            end
        end else if (q_fill.size() > 0 && q_fill[0].cyc <= cyc) begin
            f = q_fill.pop_front();
            check("fill", 1'b0, $sformatf("cyc %0d got no fill, want idx %0d data %h", cyc, f.idx, f.data));
        end

        if (i_done === 1'b1 || d_done === 1'b1) begin
            if (q_done.size() == 0)
                check("done", 1'b0, $sformatf("cyc %0d got unexpected done i%b d%b, want none", cyc, i_done, d_done));
            else begin
                d = q_done.pop_front();
                check("done", d.cyc == cyc && d_done == d.side && i_done == !d.side,
                      $sformatf("got cyc %0d i%b d%b, want cyc %0d side %0d", cyc, i_done, d_done, d.cyc, d.side));
            end
        end else if (q_done.size() > 0 && q_done[0].cyc <= cyc) begin
            d = q_done.pop_front();
            check("done", 1'b0, $sformatf("cyc %0d got no done, want side %0d", cyc, d.side));
        end

        if (i_done === 1'b1) i_done_cnt++;
        if (i_gnt === 1'b1 && !prev_i_gnt) gi_cnt++;
        if (d_gnt === 1'b1 && !prev_d_gnt) gd_cnt++;
        prev_i_gnt = i_gnt;
        prev_d_gnt = d_gnt;
    endtask

    // Transaction-level reference: a grant decided in cycle c owns the port from c+1 to its done cycle.
    task automatic model_cycle();
        logic        side, wr;
        logic [15:0] a, blk;
        int          g;
        if (rst) begin
            q_iss.delete();
            q_fill.delete();
            q_done.delete();
            act = 1'b0;
            last_served = 1'b0;
        end else if (act) begin
            if (cyc == act_end) act = 1'b0;
        end else if (i_req || d_req) begin
`ifdef CACHE_ARB_RR_EN
            side = d_req && (!i_req || last_served == 1'b0);
`else
            side = d_req;
`endif
            last_served = side;
            wr = side && d_wr;
            g  = cyc + 1;
            if (wr) begin
                a = d_addr & 16'hFFFE;
                q_iss.push_back('{g, a, 1'b1, d_wdata});
                ref_arr[a[15:1]] = d_wdata;
                act_end = g + 1;
            end else begin
                blk = (side ? d_addr : i_addr) & ~16'(2 * WORDS - 1);
                for (int k = 0; k < WORDS; k++) begin
                    a = blk + 16'(2 * k);
                    q_iss.push_back('{g + k, a, 1'b0, 16'h0});
                    q_fill.push_back('{g + MEM_LAT + k, k, ref_arr[a[15:1]], side});
                end
                act_end = g + WORDS + MEM_LAT;
            end
            q_done.push_back('{act_end, side});
            act = 1'b1;
            act_side = side;
            act_g = g;
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            monitor_cycle();
            if (mem_en === 1'b1) begin
                if (mem_wr) mem_arr[mem_addr[15:1]] = mem_wdata;
                else        sched[cyc + MEM_LAT] = mem_arr[mem_addr[15:1]];
            end
            // A reset flushes the memory pipeline but lets one stale return land in the following IDLE cycle.
            if (rst) begin
                int keys[$];
                foreach (sched[k]) if (k > cyc + 1) keys.push_back(k);
                foreach (keys[j]) sched.delete(keys[j]);
            end
            model_cycle();
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise a request at the current cycle, wait for its done (optionally dropping req early), then release.
    task automatic do_req(input bit side, input bit wr, input logic [15:0] a, input logic [15:0] wd, input int drop_at);
        bit seen = 1'b0;
        if (side) begin
            d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        for (int k = 1; k <= 1000 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (k == drop_at) begin
                if (side) d_req = 1'b0;
                else      i_req = 1'b0;
            end
            @(negedge clk);
            seen = side ? d_done : i_done;
        end
        if (!seen) check(side ? "d_timeout" : "i_timeout", 1'b0, "got no done within 1000 cycles, want done");
        @(posedge clk);
        #1;
        if (side) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap_done, snap_gi, snap_gd;
        idle(3);
        rst = 1'b0;
        idle(1);

        do_req(1'b0, 1'b0, 16'h0046, 16'h0, 0);                 // I fill, mid-block address
        idle(2);
        do_req(1'b1, 1'b1, 16'h1234, 16'hBEEF, 0);              // D single-word write
        idle(2);
        fork                                                    // simultaneous fills
            do_req(1'b0, 1'b0, 16'h2000, 16'h0, 0);
            do_req(1'b1, 1'b0, 16'h1230, 16'h0, 0);             // covers the block just written
        join
        idle(2);
        do_req(1'b0, 1'b0, 16'hFFF2, 16'h0, 3);                 // top-of-memory block, req dropped early
        idle(2);

        snap_done = i_done_cnt;                                 // reset mid-fill, req held
        fork
            do_req(1'b0, 1'b0, 16'h0100, 16'h0, 0);
            begin
                idle(6);
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
        join
        idle(2);
        check("rst_i_done_once", i_done_cnt - snap_done == 1,
              $sformatf("got %0d i_done pulses, want 1", i_done_cnt - snap_done));

        rst = 1'b1;                                             // both sides held continuously
        idle(1);
        rst = 1'b0;
        snap_gi = gi_cnt;
        snap_gd = gd_cnt;
        fork
            begin
                do_req(1'b0, 1'b0, 16'h3000, 16'h0, 0);
                do_req(1'b0, 1'b0, 16'h3010, 16'h0, 0);
            end
            begin
                do_req(1'b1, 1'b0, 16'h4000, 16'h0, 0);
                do_req(1'b1, 1'b0, 16'h4010, 16'h0, 0);
            end
        join
        check("held_grant_share", gi_cnt - snap_gi == 2 && gd_cnt - snap_gd == 2,
              $sformatf("got I %0d D %0d grants, want 2 and 2", gi_cnt - snap_gi, gd_cnt - snap_gd));
        idle(2);

        fork                                                    // randomized traffic from both sides
            for (int n = 0; n < 12; n++) begin
                idle($urandom_range(0, 3));
                do_req(1'b0, 1'b0, 16'($urandom), 16'h0, 0);
            end
            for (int n = 0; n < 12; n++) begin
                idle($urandom_range(0, 3));
                do_req(1'b1, 1'($urandom_range(0, 1)), 16'($urandom) & 16'hFFFE, 16'($urandom), 0);
            end
        join
        idle(5);
        check("scoreboard_drain", q_iss.size() == 0 && q_fill.size() == 0 && q_done.size() == 0,
              $sformatf("got %0d/%0d/%0d pending issue/fill/done, want 0/0/0", q_iss.size(), q_fill.size(), q_done.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
